// File: rtl/countdown_timer_if.sv
// Board-side signals of the countdown timer: raw buttons, load switch and value,
// the seven-segment digit and the two status lamps.
interface countdown_timer_if;
    logic       St;
    logic       Stp;
    logic       Ld;
    logic [3:0] SW;
    logic [7:0] HD1;
    logic       Run;
    logic       Done;

    modport master (output St, Stp, Ld, SW, input HD1, Run, Done);
    modport slave  (input St, Stp, Ld, SW, output HD1, Run, Done);
endinterface

// File: rtl/countdown_timer.sv
// Single-digit countdown timer: conditions raw buttons and load switch, counts down
// once per divided tick, and drives an active-low seven-segment digit.
module countdown_timer #(
    parameter int CLK_DIV   = 50000000,
    parameter int START_VAL = 9
) (
    input logic              Clk,
    input logic              R,
    countdown_timer_if.slave bus
);

    localparam int              DIV_W     = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]      START_CNT = 4'(START_VAL);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    logic [1:0]       r_stSync;
    logic [1:0]       r_stpSync;
    logic [1:0]       r_ldSync;
    logic             r_stHist;
    logic             r_stpHist;
    logic             r_ldHist;

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [3:0]       r_loadVal;
    logic [DIV_W-1:0] r_div;
    logic [7:0]       r_hd1;
    logic             r_run;
    logic             r_done;

    logic             w_startEv;
    logic             w_stopEv;
    logic             w_ldEv;
    logic             w_tick;
    logic [3:0]       w_swClamp;

    // Active-low segment codes {dp,g,f,e,d,c,b,a}; dp is lit when requested.
    function automatic logic [7:0] segCode(input logic [3:0] cnt, input logic dp);
        logic [7:0] code;
        case (cnt)
            4'd0:    code = 8'hC0;
            4'd1:    code = 8'hF9;
            4'd2:    code = 8'hA4;
            4'd3:    code = 8'hB0;
            4'd4:    code = 8'h99;
            4'd5:    code = 8'h92;
            4'd6:    code = 8'h82;
            4'd7:    code = 8'hF8;
            4'd8:    code = 8'h80;
            4'd9:    code = 8'h90;
            default: code = 8'hFF;
        endcase
        if (dp) begin
            code[7] = 1'b0;
        end
        return code;
    endfunction

    // Reset parks the synchronizers at the released level so no spurious edge follows.
    always_ff @(posedge Clk) begin
        if (R) begin
            r_stSync  <= 2'b11;
            r_stpSync <= 2'b11;
            r_ldSync  <= 2'b00;
            r_stHist  <= 1'b1;
            r_stpHist <= 1'b1;
            r_ldHist  <= 1'b0;
        end else begin
            r_stSync  <= {r_stSync[0], bus.St};
            r_stpSync <= {r_stpSync[0], bus.Stp};
            r_ldSync  <= {r_ldSync[0], bus.Ld};
            r_stHist  <= r_stSync[1];
            r_stpHist <= r_stpSync[1];
            r_ldHist  <= r_ldSync[1];
        end
    end

    assign w_startEv = r_stHist & ~r_stSync[1];
    assign w_stopEv  = r_stpHist & ~r_stpSync[1];
    assign w_ldEv    = ~r_ldHist & r_ldSync[1];
    assign w_tick    = (r_state == RUN) && (r_div == DIV_LAST);
    assign w_swClamp = (bus.SW > 4'd9) ? 4'd9 : bus.SW;

    // Outputs lag state/cnt by one edge; stop beats tick and start, load beats both.
    always_ff @(posedge Clk) begin
        if (R) begin
            r_state   <= IDLE;
            r_cnt     <= START_CNT;
            r_loadVal <= START_CNT;
            r_div     <= '0;
            r_run     <= 1'b0;
            r_done    <= 1'b0;
            r_hd1     <= segCode(START_CNT, 1'b0);
        end else begin
            r_run  <= (r_state == RUN);
            r_done <= (r_state == DONE);
            r_hd1  <= segCode(r_cnt, r_state == DONE);

            if (r_state == RUN) begin
                r_div <= w_tick ? '0 : r_div + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_ldEv) begin
                        r_cnt     <= w_swClamp;
                        r_loadVal <= w_swClamp;
                    end else if (w_startEv && (r_cnt != 4'd0)) begin
                        r_state <= RUN;
                        r_div   <= '0;
                    end
                end
                RUN: begin
                    if (w_stopEv) begin
                        r_state <= PAUSE;
                    end else if (w_tick) begin
                        if (r_cnt == 4'd1) begin
                            r_cnt   <= 4'd0;
                            r_state <= DONE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (w_stopEv) begin
                        r_state <= IDLE;
                        r_cnt   <= r_loadVal;
                    end else if (w_startEv) begin
                        r_state <= RUN;
                    end
                end
                DONE: begin
                    if (w_ldEv) begin
                        r_cnt     <= w_swClamp;
                        r_loadVal <= w_swClamp;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.HD1  = r_hd1;
    assign bus.Run  = r_run;
    assign bus.Done = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// Table-driven bench for countdown_timer with CLK_DIV=4: each vector drives the
// board inputs, waits a number of cycles and checks the digit and status lamps.
module tb_countdown_timer;

    localparam int CLK_DIV = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    countdown_timer_if bus();

    countdown_timer #(
        .CLK_DIV   (CLK_DIV),
        .START_VAL (9)
    ) dut (
        .Clk (clk),
        .R   (rst),
        .bus (bus)
    );

    typedef struct {
        logic       rst;
        logic       st;
        logic       stp;
        logic       ld;
        logic [3:0] sw;
        int         waitCyc;
        bit         chkHd1;
        logic [7:0] expHd1;
        logic       expRun;
        logic       expDone;
    } vec_t;

    typedef struct {
        int         idx;
        bit         chkHd1;
        logic [7:0] hd1;
        logic       run;
        logic       done;
    } exp_t;

    vec_t vecs[$];
    exp_t sbQ[$];
    int   vecCount  = 0;
    int   missCount = 0;

    task automatic addVec(input logic r, input logic s, input logic p, input logic l,
                          input logic [3:0] w, input int n, input bit c,
                          input logic [7:0] h, input logic ru, input logic d);
        vec_t v;
        v.rst = r; v.st = s; v.stp = p; v.ld = l; v.sw = w;
        v.waitCyc = n; v.chkHd1 = c; v.expHd1 = h; v.expRun = ru; v.expDone = d;
        vecs.push_back(v);
    endtask

    task automatic checkOutput();
        exp_t e;
        logic ok;
        vecCount++;
        if (sbQ.size() == 0) begin
            missCount++;
            $display("[TB] FAIL scoreboard: no expected entry for observed HD1=%h", bus.HD1);
            return;
        end
        e  = sbQ.pop_front();
        ok = (bus.Run === e.run) && (bus.Done === e.done) &&
             (!e.chkHd1 || (bus.HD1 === e.hd1));
        if (!ok) begin
            missCount++;
            $display("[TB] FAIL vec%0d: got HD1=%h Run=%b Done=%b, expected HD1=%h(chk=%0d) Run=%b Done=%b",
                     e.idx, bus.HD1, bus.Run, bus.Done, e.hd1, e.chkHd1, e.run, e.done);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        exp_t e;
        rst     = v.rst;
        bus.St  = v.st;
        bus.Stp = v.stp;
        bus.Ld  = v.ld;
        bus.SW  = v.sw;
        e.idx = idx; e.chkHd1 = v.chkHd1; e.hd1 = v.expHd1; e.run = v.expRun; e.done = v.expDone;
        sbQ.push_back(e);
        repeat (v.waitCyc) @(negedge clk);
        checkOutput();
    endtask

    initial begin
        int cycles;

        rst     = 1'b1;
        bus.St  = 1'b1;
        bus.Stp = 1'b1;
        bus.Ld  = 1'b0;
        bus.SW  = 4'd0;

        // rst st stp ld sw wait chk hd1 run done
        addVec(1, 1, 1, 0, 4'd0,  2, 1, 8'h90, 0, 0);
        addVec(0, 1, 1, 0, 4'd0, 20, 1, 8'h90, 0, 0);
        // load 3, run to DONE, start/stop ignored in DONE
        addVec(0, 1, 1, 1, 4'd3,  4, 1, 8'hB0, 0, 0);
        addVec(0, 0, 1, 0, 4'd3,  4, 1, 8'hB0, 1, 0);
        addVec(0, 1, 1, 0, 4'd3,  4, 1, 8'hA4, 1, 0);
        addVec(0, 1, 1, 0, 4'd3,  4, 1, 8'hF9, 1, 0);
        addVec(0, 1, 1, 0, 4'd3,  4, 1, 8'h40, 0, 1);
        addVec(0, 0, 1, 0, 4'd3,  8, 1, 8'h40, 0, 1);
        addVec(0, 1, 0, 0, 4'd3,  8, 1, 8'h40, 0, 1);
        addVec(0, 1, 1, 0, 4'd3,  2, 1, 8'h40, 0, 1);
        // load 6, pause at 5, hold, resume with the remaining divider count
        addVec(0, 1, 1, 1, 4'd6,  4, 1, 8'h82, 0, 0);
        addVec(0, 0, 1, 0, 4'd6,  6, 1, 8'h82, 1, 0);
        addVec(0, 1, 0, 0, 4'd6,  4, 1, 8'h92, 0, 0);
        addVec(0, 1, 1, 0, 4'd6, 50, 1, 8'h92, 0, 0);
        addVec(0, 0, 1, 0, 4'd6,  4, 1, 8'h92, 1, 0);
        addVec(0, 1, 1, 0, 4'd6,  3, 1, 8'h99, 1, 0);
        // pause, then abort to IDLE restores the load value
        addVec(0, 1, 0, 0, 4'd6,  4, 0, 8'h00, 0, 0);
        addVec(0, 1, 1, 0, 4'd6,  2, 0, 8'h00, 0, 0);
        addVec(0, 1, 0, 0, 4'd6,  4, 1, 8'h82, 0, 0);
        addVec(0, 1, 1, 0, 4'd6,  2, 1, 8'h82, 0, 0);
        // start and stop on the same edge in RUN pauses
        addVec(0, 0, 1, 0, 4'd6,  4, 1, 8'h82, 1, 0);
        addVec(0, 1, 1, 0, 4'd6,  1, 1, 8'h82, 1, 0);
        addVec(0, 0, 0, 0, 4'd6,  4, 1, 8'h92, 0, 0);
        addVec(0, 1, 1, 0, 4'd6,  2, 1, 8'h92, 0, 0);
        addVec(0, 1, 0, 0, 4'd6,  4, 1, 8'h82, 0, 0);
        addVec(0, 1, 1, 0, 4'd6,  2, 1, 8'h82, 0, 0);
        // held start gives one event; stop on a tick edge suppresses the decrement
        addVec(0, 0, 1, 0, 4'd6,  4, 1, 8'h82, 1, 0);
        addVec(0, 0, 0, 0, 4'd6,  4, 1, 8'h82, 0, 0);
        addVec(0, 0, 1, 0, 4'd6, 90, 1, 8'h82, 0, 0);
        addVec(0, 1, 1, 0, 4'd6,  2, 1, 8'h82, 0, 0);
        addVec(0, 1, 0, 0, 4'd6,  4, 1, 8'h82, 0, 0);
        addVec(0, 1, 1, 0, 4'd6,  2, 1, 8'h82, 0, 0);
        // oversize load clamps to 9; load during RUN is ignored
        addVec(0, 1, 1, 1, 4'd12, 4, 1, 8'h90, 0, 0);
        addVec(0, 1, 1, 0, 4'd12, 2, 1, 8'h90, 0, 0);
        addVec(0, 0, 1, 0, 4'd12, 4, 1, 8'h90, 1, 0);
        addVec(0, 1, 1, 1, 4'd2,  4, 1, 8'h80, 1, 0);
        addVec(0, 1, 1, 0, 4'd2,  2, 1, 8'h80, 1, 0);
        addVec(0, 1, 0, 0, 4'd2,  4, 1, 8'hF8, 0, 0);
        addVec(0, 1, 1, 0, 4'd2,  2, 1, 8'hF8, 0, 0);
        addVec(0, 1, 0, 0, 4'd2,  4, 1, 8'h90, 0, 0);
        addVec(0, 1, 1, 0, 4'd2,  2, 1, 8'h90, 0, 0);
        // load beats start on the same edge
        addVec(0, 0, 1, 1, 4'd4,  4, 1, 8'h99, 0, 0);
        addVec(0, 1, 1, 0, 4'd4,  2, 1, 8'h99, 0, 0);
        // start with zero count stays in IDLE
        addVec(0, 1, 1, 1, 4'd0,  4, 1, 8'hC0, 0, 0);
        addVec(0, 0, 1, 0, 4'd0,  6, 1, 8'hC0, 0, 0);
        addVec(0, 1, 1, 0, 4'd0,  2, 1, 8'hC0, 0, 0);
        // reset mid-RUN and mid-DONE
        addVec(0, 1, 1, 1, 4'd5,  4, 1, 8'h92, 0, 0);
        addVec(0, 0, 1, 0, 4'd5,  6, 1, 8'h92, 1, 0);
        addVec(1, 1, 1, 0, 4'd5,  1, 1, 8'h90, 0, 0);
        addVec(0, 1, 1, 0, 4'd5,  8, 1, 8'h90, 0, 0);
        addVec(0, 1, 1, 1, 4'd1,  4, 1, 8'hF9, 0, 0);
        addVec(0, 0, 1, 0, 4'd1,  8, 1, 8'h40, 0, 1);
        addVec(1, 1, 1, 0, 4'd1,  1, 1, 8'h90, 0, 0);
        addVec(0, 1, 1, 0, 4'd1,  4, 1, 8'h90, 0, 0);
        // reset on the edge where a start or load event would act
        addVec(0, 0, 1, 0, 4'd1,  2, 1, 8'h90, 0, 0);
        addVec(1, 1, 1, 0, 4'd1,  1, 1, 8'h90, 0, 0);
        addVec(0, 1, 1, 0, 4'd1,  6, 1, 8'h90, 0, 0);
        addVec(0, 1, 1, 1, 4'd2,  2, 1, 8'h90, 0, 0);
        addVec(1, 1, 1, 0, 4'd2,  1, 1, 8'h90, 0, 0);
        addVec(0, 1, 1, 0, 4'd2,  5, 1, 8'h90, 0, 0);
        // set up count of 2 for the Done latency check below
        addVec(0, 1, 1, 1, 4'd2,  4, 1, 8'hA4, 0, 0);
        addVec(0, 1, 1, 0, 4'd2,  2, 1, 8'hA4, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
        end

        // Two decrements from a count of 2: Done must appear 12 sampled cycles after start.
        bus.St = 1'b0;
        cycles = 0;
        while ((bus.Done !== 1'b1) && (cycles < 40)) begin
            @(negedge clk);
            cycles++;
        end
        vecCount++;
        if ((cycles != 12) || (bus.HD1 !== 8'h40) || (bus.Run !== 1'b0)) begin
            missCount++;
            $display("[TB] FAIL done_latency: got %0d cycles HD1=%h Run=%b, expected 12 cycles HD1=40 Run=0",
                     cycles, bus.HD1, bus.Run);
        end
        bus.St = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
